// File: rtl/reg_scoreboard.sv
// Register write scoreboard: per-register in-flight write counters,
// RAW/overflow issue stalls, flush, and a drain handshake.
module reg_scoreboard #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int CNT_W            = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] issue_addr_r1,
  input  logic                        issue_r1_used,
  input  logic [REG_ADDRESS_SIZE-1:0] issue_addr_r2,
  input  logic                        issue_r2_used,
  input  logic [REG_ADDRESS_SIZE-1:0] issue_addr_rd,
  input  logic                        issue_we,
  input  logic                        wb_valid,
  input  logic [REG_ADDRESS_SIZE-1:0] wb_addr,
  input  logic                        flush,
  input  logic                        drain_req,
  output logic                        stall,
  output logic                        issue_fire,
  output logic [REG_ADDRESS_SIZE+1:0] outstanding,
  output logic                        drain_done,
  output logic                        wb_err
);

  localparam int NREG = 1 << REG_ADDRESS_SIZE;
  localparam int OW   = REG_ADDRESS_SIZE + 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [OW-1:0]    outstanding_q;
  logic [OW-1:0]    outstanding_d;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             wb_err_q;
  logic             wb_err_d;

  logic hazard;
  logic overflow;
  logic inc;
  logic dec;
  logic wb_bad;
  logic inc_hit;
  logic dec_hit;

  // Hazards look only at registered counts; no writeback bypass.
  always_comb begin
    hazard = (issue_r1_used && (cnt_q[issue_addr_r1] != '0))
           | (issue_r2_used && (cnt_q[issue_addr_r2] != '0));
    overflow = issue_we && (cnt_q[issue_addr_rd] == CNT_MAX);
    stall = issue_valid
          & (hazard | overflow | (state_q != ST_RUN) | flush);
    issue_fire = issue_valid & ~stall;
    inc = issue_fire & issue_we;
    dec = wb_valid & (cnt_q[wb_addr] != '0);
    wb_bad = wb_valid & (cnt_q[wb_addr] == '0);
  end

  always_comb begin
    inc_hit = 1'b0;
    dec_hit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      inc_hit = inc && (issue_addr_rd == REG_ADDRESS_SIZE'(i));
      dec_hit = dec && (wb_addr == REG_ADDRESS_SIZE'(i));
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_hit && !dec_hit) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_hit && !inc_hit) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (flush) begin
      outstanding_d = '0;
    end else if (inc && !dec) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (dec && !inc) begin
      outstanding_d = outstanding_q - OW'(1);
    end
  end

  always_comb begin
    wb_err_d = wb_err_q | wb_bad;
  end

  // Dropping drain_req while draining wins over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)              state_d = ST_RUN;
        else if (outstanding_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      outstanding_q <= '0;
      state_q       <= ST_RUN;
      wb_err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      outstanding_q <= outstanding_d;
      state_q       <= state_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign outstanding = outstanding_q;
  assign drain_done  = (state_q == ST_DONE);
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic
// against a counter-array reference model.
module tb_reg_scoreboard;

  localparam int A    = 5;
  localparam int NREG = 32;
  localparam int MAXC = 3;

  logic         clk;
  logic         rst;
  logic         iv;
  logic [A-1:0] r1;
  logic         r1u;
  logic [A-1:0] r2;
  logic         r2u;
  logic [A-1:0] rd;
  logic         we;
  logic         wbv;
  logic [A-1:0] wba;
  logic         fl;
  logic         dr;
  logic         stall;
  logic         issue_fire;
  logic [A+1:0] outstanding;
  logic         drain_done;
  logic         wb_err;

  int checks;
  int errors;

  int    mc[NREG];
  int    nc[NREG];
  int    mout;
  bit    merr;
  string mstate;

  reg_scoreboard #(.REG_ADDRESS_SIZE(A), .CNT_W(2)) dut (
    .clk(clk),
    .reset(rst),
    .issue_valid(iv),
    .issue_addr_r1(r1),
    .issue_r1_used(r1u),
    .issue_addr_r2(r2),
    .issue_r2_used(r2u),
    .issue_addr_rd(rd),
    .issue_we(we),
    .wb_valid(wbv),
    .wb_addr(wba),
    .flush(fl),
    .drain_req(dr),
    .stall(stall),
    .issue_fire(issue_fire),
    .outstanding(outstanding),
    .drain_done(drain_done),
    .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_stall();
    bit busy;
    busy = (r1u && mc[r1] != 0) || (r2u && mc[r2] != 0)
        || (we && mc[rd] == MAXC) || (mstate != "RUN") || fl;
    return iv && busy;
  endfunction

  task automatic model_update();
    bit fire;
    int old_out;
    if (rst) begin
      foreach (mc[i]) mc[i] = 0;
      mout = 0;
      merr = 0;
      mstate = "RUN";
    end else begin
      fire = iv && !m_stall();
      old_out = mout;
      nc = mc;
      if (wbv) begin
        if (mc[wba] > 0) begin
          nc[wba] = nc[wba] - 1;
          mout = mout - 1;
        end else begin
          merr = 1;
        end
      end
      if (fire && we) begin
        nc[rd] = nc[rd] + 1;
        mout = mout + 1;
      end
      if (fl) begin
        foreach (nc[i]) nc[i] = 0;
        mout = 0;
      end
      mc = nc;
      if (mstate == "RUN") begin
        if (dr) mstate = "DRAIN";
      end else if (mstate == "DRAIN") begin
        if (!dr) mstate = "RUN";
        else if (old_out == 0) mstate = "DONE";
      end else begin
        if (!dr) mstate = "RUN";
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; iv = 0; r1 = '0; r1u = 0; r2 = '0; r2u = 0;
    rd = '0; we = 0; wbv = 0; wba = '0; fl = 0; dr = 0;
  endtask

  task automatic issue_rd(input int a);
    idle();
    iv = 1; rd = A'(a); we = 1;
    tick();
    idle();
  endtask

  task automatic retire(input int a);
    idle();
    wbv = 1; wba = A'(a);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1; fl = 1; iv = 1; we = 1; rd = 5'd3; wbv = 1; wba = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (outstanding !== 7'd0) begin
      errors++;
      $display("FAIL reset_outstanding got %0d want 0", outstanding);
    end
    checks++;
    if (drain_done !== 1'b0 || wb_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got dd=%b err=%b want 0 0",
               drain_done, wb_err);
    end
    iv = 1; r1 = 5'd4; r1u = 1; r2 = 5'd6; r2u = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL reset_issue got stall=%b fire=%b want 0 1",
               stall, issue_fire);
    end
    idle();
  endtask

  task automatic test_basic();
    idle();
    iv = 1; rd = 5'd3; we = 1; r1 = 5'd1; r1u = 1;
    #1;
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL basic_fire got %b want 1", issue_fire);
    end
    tick();
    idle();
    checks++;
    if (outstanding !== 7'd1) begin
      errors++;
      $display("FAIL basic_outstanding got %0d want 1", outstanding);
    end
    iv = 1; r2 = 5'd3; r2u = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL basic_r2_hazard got %b want 1", stall);
    end
    retire(3);
  endtask

  task automatic test_raw_hazard();
    issue_rd(5);
    iv = 1; r1 = 5'd5; r1u = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall got %b want 1", stall);
    end
    tick();
    wbv = 1; wba = 5'd5;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_no_bypass got %b want 1", stall);
    end
    tick();
    wbv = 0;
    #1;
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL raw_release got %b want 1", issue_fire);
    end
    tick();
    idle();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) issue_rd(7);
    iv = 1; rd = 5'd7; we = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL ovf_stall got %b want 1", stall);
    end
    wbv = 1; wba = 5'd7;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL ovf_same_cycle got %b want 1", stall);
    end
    tick();
    wbv = 0;
    #1;
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fire got %b want 1", issue_fire);
    end
    tick();
    idle();
    checks++;
    if (outstanding !== 7'd3) begin
      errors++;
      $display("FAIL ovf_outstanding got %0d want 3", outstanding);
    end
    for (int k = 0; k < 3; k++) retire(7);
  endtask

  task automatic test_same_reg();
    issue_rd(4);
    iv = 1; rd = 5'd4; we = 1; wbv = 1; wba = 5'd4;
    #1;
    checks++;
    if (issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL same_fire got %b want 1", issue_fire);
    end
    tick();
    idle();
    checks++;
    if (outstanding !== 7'd1) begin
      errors++;
      $display("FAIL same_outstanding got %0d want 1", outstanding);
    end
    iv = 1; r1 = 5'd4; r1u = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL same_cnt_kept got %b want 1", stall);
    end
    retire(4);
  endtask

  task automatic test_drain();
    issue_rd(1);
    issue_rd(2);
    dr = 1;
    tick();
    iv = 1; rd = 5'd9; we = 1;
    #1;
    checks++;
    if (stall !== 1'b1 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_stall got stall=%b dd=%b want 1 0",
               stall, drain_done);
    end
    wbv = 1; wba = 5'd1;
    tick();
    wba = 5'd2;
    tick();
    wbv = 0;
    #1;
    checks++;
    if (drain_done !== 1'b0 || outstanding !== 7'd0) begin
      errors++;
      $display("FAIL drain_pending got dd=%b out=%0d want 0 0",
               drain_done, outstanding);
    end
    tick();
    checks++;
    if (drain_done !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL drain_done got dd=%b stall=%b want 1 1",
               drain_done, stall);
    end
    dr = 0;
    tick();
    checks++;
    if (drain_done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit got dd=%b stall=%b want 0 0",
               drain_done, stall);
    end
    idle();
  endtask

  task automatic test_flush_err();
    issue_rd(1);
    issue_rd(2);
    issue_rd(3);
    fl = 1; iv = 1; rd = 5'd8; we = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall got %b want 1", stall);
    end
    tick();
    idle();
    checks++;
    if (outstanding !== 7'd0) begin
      errors++;
      $display("FAIL flush_outstanding got %0d want 0", outstanding);
    end
    retire(2);
    tick();
    tick();
    checks++;
    if (wb_err !== 1'b1) begin
      errors++;
      $display("FAIL wb_err_sticky got %b want 1", wb_err);
    end
    rst = 1;
    tick();
    idle();
    checks++;
    if (wb_err !== 1'b0) begin
      errors++;
      $display("FAIL wb_err_reset got %b want 0", wb_err);
    end
  endtask

  task automatic test_reset_override();
    issue_rd(6);
    dr = 1;
    tick();
    rst = 1; fl = 1; wbv = 1; wba = 5'd0;
    iv = 1; rd = 5'd6; we = 1;
    tick();
    idle();
    iv = 1; r1 = 5'd6; r1u = 1; rd = 5'd6; we = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || outstanding !== 7'd0 ||
        wb_err !== 1'b0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_override got st=%b out=%0d err=%b dd=%b",
               stall, outstanding, wb_err, drain_done);
    end
    idle();
  endtask

  task automatic test_random();
    bit es;
    idle();
    rst = 1;
    tick();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) < 4) dr = ~dr;
      iv  = ($urandom_range(0, 3) != 0);
      r1  = A'($urandom_range(0, 7));
      r1u = 1'($urandom_range(0, 1));
      r2  = A'($urandom_range(0, 7));
      r2u = 1'($urandom_range(0, 1));
      rd  = A'($urandom_range(0, 7));
      we  = ($urandom_range(0, 3) != 0);
      wbv = 1'($urandom_range(0, 1));
      wba = A'($urandom_range(0, 7));
      #1;
      es = m_stall();
      checks++;
      if (stall !== es || issue_fire !== (iv && !es)) begin
        errors++;
        $display("FAIL rnd_issue cyc %0d got st=%b f=%b want %b %b",
                 n, stall, issue_fire, es, iv && !es);
      end
      checks++;
      if (outstanding !== (A+2)'(mout)) begin
        errors++;
        $display("FAIL rnd_outstanding cyc %0d got %0d want %0d",
                 n, outstanding, mout);
      end
      checks++;
      if (drain_done !== (mstate == "DONE") || wb_err !== merr) begin
        errors++;
        $display("FAIL rnd_flags cyc %0d got dd=%b err=%b want %b %b",
                 n, drain_done, wb_err, mstate == "DONE", merr);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    foreach (mc[i]) mc[i] = 0;
    mout = 0;
    merr = 0;
    mstate = "RUN";
    idle();
    test_reset();
    test_basic();
    test_raw_hazard();
    test_overflow();
    test_same_reg();
    test_drain();
    test_flush_err();
    test_reset_override();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
